fpga_config_loader: RTL

- Upstream configuration stage for the FPGA fabric model.
- Accepts the configuration image as a valid/ready stream of 32-bit words and writes each word over a registered config bus into the fabric's LUT memories and switch-box configure registers.
- Holds the fabric disabled until a complete, valid image has been loaded.
- Replaces hierarchical back-door loading in benches with a synthesizable front door.

---
 rtl/fpga_cfg_pkg.sv | 26 ++
 rtl/cfg_watchdog.sv | 38 +++
 rtl/fpga_config_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared constants, fabric config address map and loader state encoding
// for the FPGA configuration front door.
package fpga_cfg_pkg;

    localparam int CFG_WORD_W    = 32;
    localparam int NUM_CFG_WORDS = 50;

    // Each LUT takes two words; switch boxes follow the LUT block.
    localparam int LUT_CFG_BASE  = 0;
    localparam int LUT_CFG_WORDS = 28;
    localparam int SW_CFG_BASE   = 28;
    localparam int SW_CFG_WORDS  = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } ldr_state_e;

    function automatic logic is_busy(ldr_state_e s);
        return (s == ST_LOAD) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/cfg_watchdog.sv
// Idle-cycle watchdog for the config loader: counts enabled cycles without a
// clear and flags the cycle whose edge would complete TIMEOUT idle cycles.
module cfg_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = clock ^ reset_n ^ clr ^ en;
            assign timeout   = 1'b0;
        end else begin : g_on
            logic [CNT_W-1:0] idle_cnt;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    idle_cnt <= '0;
                else if (clr || !en)
                    idle_cnt <= '0;
                else
                    idle_cnt <= idle_cnt + 1'b1;
            end

            // Fires on the idle cycle that ends at TIMEOUT, so the state change
            // lands exactly TIMEOUT cycles after the last acceptance.
            assign timeout = en && !clr && (idle_cnt == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/fpga_config_loader.sv
// Streams a configuration image onto the registered fabric config bus and
// gates fabric_en until the load completes. FPGA_CONFIG_CHECKSUM_EN adds a trailing XOR check word.
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int NUM_WORDS = NUM_CFG_WORDS,
    parameter int ADDR_W    = 6,
    parameter int TIMEOUT   = 256
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [CFG_WORD_W-1:0] in_data,
    output logic                  in_ready,
    output logic                  cfg_we,
    output logic [ADDR_W-1:0]     cfg_addr,
    output logic [CFG_WORD_W-1:0] cfg_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  fabric_en
);

    ldr_state_e        state, state_nxt;
    logic [ADDR_W-1:0] word_cnt;
    logic              accept, load_acc, last_word, start_session, wd_timeout;

    assign in_ready      = is_busy(state);
    assign busy          = is_busy(state);
    assign done          = (state == ST_DONE);
    assign fabric_en     = (state == ST_DONE);
    assign error         = (state == ST_ERROR);
    assign accept        = in_valid && in_ready;
    assign load_acc      = accept && (state == ST_LOAD);
    assign last_word     = (word_cnt == ADDR_W'(NUM_WORDS - 1));
    assign start_session = start && !busy;

`ifdef FPGA_CONFIG_CHECKSUM_EN
    logic [CFG_WORD_W-1:0] csum_acc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            csum_acc <= '0;
        else if (start_session)
            csum_acc <= '0;
        else if (load_acc)
            csum_acc <= csum_acc ^ in_data;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start)
                    state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_acc && last_word)
`ifdef FPGA_CONFIG_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_DONE;
`endif
                else if (wd_timeout)
                    state_nxt = ST_ERROR;
            end
`ifdef FPGA_CONFIG_CHECKSUM_EN
            ST_CHECK: begin
                if (accept)
                    state_nxt = (in_data == csum_acc) ? ST_DONE : ST_ERROR;
                else if (wd_timeout)
                    state_nxt = ST_ERROR;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus address/data hold between strobes; the counter parks on the last index.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= '0;
            cfg_we   <= 1'b0;
            cfg_addr <= '0;
            cfg_data <= '0;
        end else begin
            cfg_we <= load_acc;
            if (start_session)
                word_cnt <= '0;
            else if (load_acc && !last_word)
                word_cnt <= word_cnt + 1'b1;
            if (load_acc) begin
                cfg_addr <= word_cnt;
                cfg_data <= in_data;
            end
        end
    end

    cfg_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (accept || start_session),
        .en      (busy),
        .timeout (wd_timeout)
    );

endmodule
